// File: rtl/uart_resp_encode.sv
// uart_resp_encode: frames read-response words into a byte stream for uart_ip.
// Frame: HDR0, HDR1, addr[31:0] MSB first, data[15:0] MSB first, optional CHK.
// Build option: define UART_RESP_CHKSUM_EN to append the 8-bit checksum byte.
// One pending response is held while a frame is in flight.
module uart_resp_encode #(
    parameter logic [7:0]  HDR0         = 8'hAA,
    parameter logic [7:0]  HDR1         = 8'h55,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rd_resp_v,
    input  logic [31:0] i_rd_resp_addr,
    input  logic [15:0] i_rd_resp_data,
    output logic        o_resp_ready,
    input  logic        i_tx_busy,
    output logic        o_din_v,
    output logic [7:0]  o_din,
    output logic        o_frame_busy,
    output logic        o_frame_done
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_SEND      = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_NEXT      = 3'd5;

`ifdef UART_RESP_CHKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd8;
`else
    localparam logic [3:0] LAST_IDX = 4'd7;
`endif

    localparam logic [3:0] TO_LAST = 4'(BUSY_TIMEOUT - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_state_d;
    logic        r_pend_v;
    logic [31:0] r_pend_addr;
    logic [15:0] r_pend_data;
    logic [31:0] r_frm_addr;
    logic [15:0] r_frm_data;
    logic [3:0]  r_byte_idx;
    logic [3:0]  r_to_cnt;
    logic        w_accept;
    logic        w_din_v;
    logic        w_last;
    logic [7:0]  w_byte;

`ifdef UART_RESP_CHKSUM_EN
    logic [7:0]  r_chk;
    logic [7:0]  w_chk_sum;

    // Checksum over the six payload bytes of the entry being loaded; headers excluded.
    always_comb begin
        w_chk_sum = r_pend_addr[31:24] + r_pend_addr[23:16] + r_pend_addr[15:8]
                  + r_pend_addr[7:0] + r_pend_data[15:8] + r_pend_data[7:0];
    end
`endif

    // The slot is free when empty, or in LOAD where it is being emptied this cycle.
    always_comb begin
        o_resp_ready = !r_pend_v || (r_state == S_LOAD);
        w_accept     = i_rd_resp_v && o_resp_ready;
        w_din_v      = (r_state == S_SEND) && !i_tx_busy;
        w_last       = (r_byte_idx == LAST_IDX);
        o_din_v      = w_din_v;
        o_din        = w_din_v ? w_byte : 8'h00;
        o_frame_busy = (r_state != S_IDLE);
        o_frame_done = (r_state == S_NEXT) && w_last;
    end

    // Pending slot: capture on accept, release when LOAD takes the entry.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_pend_v    <= 1'b0;
            r_pend_addr <= 32'h0;
            r_pend_data <= 16'h0;
        end else if (w_accept) begin
            r_pend_v    <= 1'b1;
            r_pend_addr <= i_rd_resp_addr;
            r_pend_data <= i_rd_resp_data;
        end else if (r_state == S_LOAD) begin
            r_pend_v    <= 1'b0;
        end
    end

    // Frame byte select, MSB first.
    always_comb begin
        w_byte = 8'h00;
        case (r_byte_idx)
            4'd0:    w_byte = HDR0;
            4'd1:    w_byte = HDR1;
            4'd2:    w_byte = r_frm_addr[31:24];
            4'd3:    w_byte = r_frm_addr[23:16];
            4'd4:    w_byte = r_frm_addr[15:8];
            4'd5:    w_byte = r_frm_addr[7:0];
            4'd6:    w_byte = r_frm_data[15:8];
            4'd7:    w_byte = r_frm_data[7:0];
`ifdef UART_RESP_CHKSUM_EN
            4'd8:    w_byte = r_chk;
`endif
            default: w_byte = 8'h00;
        endcase
    end

    // FSM next-state.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            S_IDLE:      if (r_pend_v) w_state_d = S_LOAD;
            S_LOAD:      w_state_d = S_SEND;
            S_SEND:      if (!i_tx_busy) w_state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (i_tx_busy) begin
                    w_state_d = S_WAIT_DONE;
                end else if (r_to_cnt == TO_LAST) begin
                    // uart_ip never acknowledged: treat the byte as sent
                    w_state_d = S_NEXT;
                end
            end
            S_WAIT_DONE: if (!i_tx_busy) w_state_d = S_NEXT;
            S_NEXT:      w_state_d = w_last ? S_IDLE : S_SEND;
            default:     w_state_d = S_IDLE;
        endcase
    end

    // FSM state and frame datapath.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_frm_addr <= 32'h0;
            r_frm_data <= 16'h0;
            r_byte_idx <= 4'd0;
            r_to_cnt   <= 4'd0;
`ifdef UART_RESP_CHKSUM_EN
            r_chk      <= 8'h00;
`endif
        end else begin
            r_state <= w_state_d;
            case (r_state)
                S_LOAD: begin
                    r_frm_addr <= r_pend_addr;
                    r_frm_data <= r_pend_data;
                    r_byte_idx <= 4'd0;
`ifdef UART_RESP_CHKSUM_EN
                    r_chk      <= w_chk_sum;
`endif
                end
                S_SEND:      if (w_din_v) r_to_cnt <= 4'd0;
                S_WAIT_BUSY: if (!i_tx_busy) r_to_cnt <= r_to_cnt + 4'd1;
                S_NEXT:      if (!w_last) r_byte_idx <= r_byte_idx + 4'd1;
                default:     ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_resp_encode.sv
// tb_uart_resp_encode: directed bench for uart_resp_encode.
// Frame length follows UART_RESP_CHKSUM_EN, as in the design.
module tb_uart_resp_encode;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_resp_v;
    logic [31:0] rd_resp_addr;
    logic [15:0] rd_resp_data;
    logic        resp_ready;
    logic        tx_busy;
    logic        din_v;
    logic [7:0]  din;
    logic        frame_busy;
    logic        frame_done;

`ifdef UART_RESP_CHKSUM_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    always #5 clk = ~clk;

    uart_resp_encode dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_rd_resp_v    (rd_resp_v),
        .i_rd_resp_addr (rd_resp_addr),
        .i_rd_resp_data (rd_resp_data),
        .o_resp_ready   (resp_ready),
        .i_tx_busy      (tx_busy),
        .o_din_v        (din_v),
        .o_din          (din),
        .o_frame_busy   (frame_busy),
        .o_frame_done   (frame_done)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Byte capture, protocol watch and uart_ip busy model.
    logic [7:0] q_byte[$];
    int         q_cyc[$];
    int         q_done[$];
    int         cyc      = 0;
    int         viol     = 0;
    logic       prev_dv  = 1'b0;
    int         busy_cnt = 0;
    logic       busy_en  = 1'b1;

    assign tx_busy = (busy_cnt != 0);

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        prev_dv <= din_v;
        if (din_v) begin
            q_byte.push_back(din);
            q_cyc.push_back(cyc);
            if (tx_busy || prev_dv) viol <= viol + 1;
        end
        if (frame_done) q_done.push_back(cyc);
        if (busy_en && din_v) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    task automatic clear_q();
        q_byte.delete();
        q_cyc.delete();
        q_done.delete();
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_req(input logic [31:0] a, input logic [15:0] d);
        int k = 0;
        rd_resp_addr = a;
        rd_resp_data = d;
        rd_resp_v    = 1'b1;
        while (!resp_ready && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("accept_timeout", 32'(k < 3000), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rd_resp_v = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        while (q_done.size() < n && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("done_timeout", 32'(q_done.size() >= n), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int base, input logic [31:0] a,
                               input logic [15:0] d, input logic [7:0] chk);
        logic [7:0] e[9];
        e[0] = 8'hAA;      e[1] = 8'h55;
        e[2] = a[31:24];   e[3] = a[23:16];
        e[4] = a[15:8];    e[5] = a[7:0];
        e[6] = d[15:8];    e[7] = d[7:0];
        e[8] = chk;
        check({tag, "_len"}, 32'(q_byte.size() >= base + NB), 32'd1);
        for (int i = 0; i < NB; i++) begin
            if (base + i < q_byte.size())
                check($sformatf("%s_b%0d", tag, i), 32'(q_byte[base + i]), 32'(e[i]));
        end
    endtask

    initial begin
        int c_ret;
        int n_keep;
        int k;

        // 1: reset held with a request present
        reset        = 1'b0;
        rd_resp_v    = 1'b1;
        rd_resp_addr = 32'hDEADBEEF;
        rd_resp_data = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_din_v", 32'(din_v), 32'd0);
            check("rst_ready", 32'(resp_ready), 32'd1);
            check("rst_fbusy", 32'(frame_busy), 32'd0);
        end
        rd_resp_v = 1'b0;
        reset     = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_ready", 32'(resp_ready), 32'd1);
        check("post_rst_fbusy", 32'(frame_busy), 32'd0);
        check("post_rst_bytes", 32'(q_byte.size()), 32'd0);

        // 2: basic frame and first-byte latency
        clear_q();
        send_req(32'h0000_0010, 16'h0003);
        c_ret = cyc;
        check("t2_ready_low", 32'(resp_ready), 32'd0);
        wait_done(1);
        repeat (20) @(negedge clk);
        check("t2_done_cnt", 32'(q_done.size()), 32'd1);
        check("t2_latency", 32'(q_cyc[0]), 32'(c_ret + 2));
        check_frame("t2", 0, 32'h0000_0010, 16'h0003, 8'h13);

        // 3: checksum wrap
        clear_q();
        send_req(32'hFFFF_FFFF, 16'hFFFF);
        wait_done(1);
        check_frame("t3", 0, 32'hFFFF_FFFF, 16'hFFFF, 8'hFA);

        // 4: back-to-back with a held third request
        repeat (3) @(negedge clk);
        clear_q();
        send_req(32'h1234_5678, 16'hABCD);
        k = 0;
        while (q_byte.size() < 3 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        send_req(32'h0000_0001, 16'h0002);
        check("t4_b_ready_low", 32'(resp_ready), 32'd0);
        check("t4_b_mid_frame", 32'(q_done.size()), 32'd0);
        send_req(32'h0A0B_0C0D, 16'h0E0F);
        check("t4_c_after_a", 32'(q_done.size()), 32'd1);
        check("t4_c_fbusy", 32'(frame_busy), 32'd1);
        check("t4_c_ready_low", 32'(resp_ready), 32'd0);
        wait_done(3);
        check_frame("t4a", 0, 32'h1234_5678, 16'hABCD, 8'h8C);
        check_frame("t4b", NB, 32'h0000_0001, 16'h0002, 8'h03);
        check_frame("t4c", 2 * NB, 32'h0A0B_0C0D, 16'h0E0F, 8'h4B);
        check("t4_gap_ab", 32'(q_cyc[NB] - q_done[0]), 32'd3);
        check("t4_gap_bc", 32'(q_cyc[2 * NB] - q_done[1]), 32'd3);

        // 5: uart_ip never goes busy; each byte times out
        repeat (15) @(negedge clk);
        busy_en = 1'b0;
        clear_q();
        send_req(32'h0000_0020, 16'h0004);
        wait_done(1);
        check_frame("t5", 0, 32'h0000_0020, 16'h0004, 8'h24);
        check("t5_pace_first", 32'(q_cyc[1] - q_cyc[0]), 32'd6);
        check("t5_pace_last", 32'(q_cyc[NB - 1] - q_cyc[NB - 2]), 32'd6);
        busy_en = 1'b1;

        // 6: reset during byte 4, then a fresh frame
        @(negedge clk);
        clear_q();
        send_req(32'h1122_3344, 16'h5566);
        k = 0;
        while (q_byte.size() < 4 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        reset = 1'b0;
        @(negedge clk);
        check("t6_rst_din_v", 32'(din_v), 32'd0);
        check("t6_rst_din", 32'(din), 32'd0);
        check("t6_rst_ready", 32'(resp_ready), 32'd1);
        check("t6_rst_fbusy", 32'(frame_busy), 32'd0);
        check("t6_rst_fdone", 32'(frame_done), 32'd0);
        @(negedge clk);
        reset  = 1'b1;
        n_keep = q_byte.size();
        repeat (60) @(negedge clk);
        check("t6_no_resume", 32'(q_byte.size()), 32'(n_keep));
        check("t6_no_done", 32'(q_done.size()), 32'd0);
        send_req(32'h0000_0030, 16'h0005);
        wait_done(1);
        check_frame("t6", n_keep, 32'h0000_0030, 16'h0005, 8'h35);

        check("proto_viol", 32'(viol), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
